// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 classic arbiter: round-robin grant held for a whole cyc,
// with an unacknowledged-stb watchdog that aborts the transfer and pulses err.
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_w,
    input  logic [DW/8-1:0] m0_sel,
    output logic [DW-1:0]   m0_dat_r,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_w,
    input  logic [DW/8-1:0] m1_sel,
    output logic [DW-1:0]   m1_dat_r,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_w,
    output logic [DW/8-1:0] s_sel,
    input  logic [DW-1:0]   s_dat_r,
    input  logic            s_ack,
    output logic [1:0]      gnt
);

    typedef enum logic [1:0] {IDLE, G0, G1, ABORT} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg;
    logic        last_reg;
    logic [15:0] cnt_reg;
    logic        granted;
    logic        timeout;

    assign gnt     = {state_reg == G1, state_reg == G0};
    assign granted = gnt[0] | gnt[1];

    // Fires on the counter value alone so a master dropping cyc that same cycle still gets aborted.
    assign timeout = granted && (cnt_reg == CNT_LAST) && !s_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (m0_cyc && (!m1_cyc || last_reg)) begin
                        state_reg <= G0;
                        last_reg  <= 1'b0;
                    end else if (m1_cyc) begin
                        state_reg <= G1;
                        last_reg  <= 1'b1;
                    end
                end
                G0, G1: begin
                    if (timeout) begin
                        state_reg <= ABORT;
                        cnt_reg   <= '0;
                    end else if (!s_cyc) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (s_stb && !s_ack) begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                default: begin
                    // last_reg already names the aborted master, so the next tie goes to the other one.
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign s_cyc   = (gnt[0] & m0_cyc) | (gnt[1] & m1_cyc);
    assign s_stb   = (gnt[0] & m0_stb) | (gnt[1] & m1_stb);
    assign s_we    = gnt[1] ? m1_we    : m0_we;
    assign s_adr   = gnt[1] ? m1_adr   : m0_adr;
    assign s_dat_w = gnt[1] ? m1_dat_w : m0_dat_w;
    assign s_sel   = gnt[1] ? m1_sel   : m0_sel;

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;
    assign m0_ack   = s_ack & gnt[0];
    assign m1_ack   = s_ack & gnt[1];
    assign m0_err   = (state_reg == ABORT) & ~last_reg;
    assign m1_err   = (state_reg == ABORT) &  last_reg;

endmodule
